// File: rtl/maze_controller_if.sv
// Controller/datapath link for the maze search engine: datapath status flows
// to the controller, datapath strobes flow back.
interface maze_controller_if;
    logic       at_goal;
    logic       inb;
    logic       blocked;
    logic [1:0] cnt;
    logic       carryOut;
    logic [1:0] stfront;
    logic       empty;
    logic       doneRun;

    logic       enx;
    logic       eny;
    logic       ensz;
    logic       enCnt;
    logic       ldcnt;
    logic       rstcnt;
    logic       rstpnt;
    logic       pop;
    logic       ins;
    logic       sel;
    logic       selAlu;
    logic       shiftl;
    logic       mem_wr;

    modport master (
        input  at_goal, inb, blocked, cnt, carryOut, stfront, empty, doneRun,
        output enx, eny, ensz, enCnt, ldcnt, rstcnt, rstpnt, pop, ins,
               sel, selAlu, shiftl, mem_wr
    );

    modport slave (
        output at_goal, inb, blocked, cnt, carryOut, stfront, empty, doneRun,
        input  enx, eny, ensz, enCnt, ldcnt, rstcnt, rstpnt, pop, ins,
               sel, selAlu, shiftl, mem_wr
    );
endinterface

// File: rtl/maze_controller.sv
// Depth-first maze search controller for a 16x16 maze with a 256-deep path
// stack; after a successful search it replays the stored path.
module maze_controller (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run,
    maze_controller_if.master dp,
    output logic              busy,
    output logic              found,
    output logic              fail,
    output logic              dir_valid,
    output logic              done
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CHECK, S_BACK, S_FOUND, S_REPLAY, S_DONE, S_FAIL
    } state_t;

    state_t state, nxt;

    // Exhaustion is decided from cnt directly; the counter carry is redundant here.
    logic unused_carry;
    assign unused_carry = dp.carryOut;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        dp.enx    = 1'b0;
        dp.eny    = 1'b0;
        dp.ensz   = 1'b0;
        dp.enCnt  = 1'b0;
        dp.ldcnt  = 1'b0;
        dp.rstcnt = 1'b0;
        dp.rstpnt = 1'b0;
        dp.pop    = 1'b0;
        dp.ins    = 1'b0;
        dp.sel    = 1'b0;
        dp.selAlu = 1'b0;
        dp.shiftl = 1'b0;
        dp.mem_wr = 1'b0;
        busy      = 1'b0;
        found     = 1'b0;
        fail      = 1'b0;
        dir_valid = 1'b0;
        done      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) nxt = S_INIT;
            end
            S_INIT: begin
                busy      = 1'b1;
                dp.rstcnt = 1'b1;
                dp.rstpnt = 1'b1;
                dp.mem_wr = 1'b1;
                nxt       = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (dp.at_goal) begin
                    nxt = S_FOUND;
                end else begin
                    // sel/selAlu steer the candidate-cell ALU on every probe.
                    dp.sel    = dp.cnt[0];
                    dp.selAlu = dp.cnt[1];
                    if (dp.inb && !dp.blocked) begin
                        dp.enx    = ~dp.cnt[0];
                        dp.eny    = dp.cnt[0];
                        dp.ins    = 1'b1;
                        dp.ensz   = 1'b1;
                        dp.rstcnt = 1'b1;
                        dp.mem_wr = 1'b1;
                    end else if (dp.cnt != 2'd3) begin
                        dp.enCnt = 1'b1;
                    end else begin
                        nxt = S_BACK;
                    end
                end
            end
            S_BACK: begin
                busy = 1'b1;
                if (dp.empty) begin
                    nxt = S_FAIL;
                end else begin
                    dp.sel    = dp.stfront[0];
                    dp.selAlu = ~dp.stfront[1];
                    dp.enx    = ~dp.stfront[0];
                    dp.eny    = dp.stfront[0];
                    dp.pop    = 1'b1;
                    dp.ensz   = 1'b1;
                    dp.ldcnt  = 1'b1;
                    if (dp.stfront != 2'd3) nxt = S_CHECK;
                end
            end
            S_FOUND: begin
                busy  = 1'b1;
                found = 1'b1;
                if (run) begin
                    dp.rstpnt = 1'b1;
                    nxt       = S_REPLAY;
                end
            end
            S_REPLAY: begin
                busy = 1'b1;
                if (dp.empty) begin
                    nxt = S_DONE;
                end else begin
                    dir_valid = 1'b1;
                    if (dp.doneRun) nxt = S_DONE;
                    else            dp.shiftl = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) nxt = S_INIT;
            end
            S_FAIL: begin
                fail = 1'b1;
                if (start) nxt = S_INIT;
            end
            default: nxt = S_IDLE;
        endcase
    end
endmodule
